data_unpack_arb: RTL and testbench

Packet-level round-robin arbiter that shares one `data_unpack` instance between `NUM_REQ` 32-bit packet streams. It sits directly in front of the unpacker, grants one requester per packet and locks the grant from SOP to EOP. It discards out-of-packet words on idle ports and pre-arbitrates on the EOP cycle, so back-to-back packets from different ports reach the unpacker with zero dead cycles.

---
 rtl/data_unpack_pkg.sv | 12 +
 rtl/data_unpack_arb_rr_pick.sv | 28 ++
 rtl/data_unpack_arb.sv | 159 +++++++++++++++
 tb/tb_data_unpack_arb.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_unpack_pkg.sv
// Shared types and limits for the data_unpack front-end arbiter.
package data_unpack_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    localparam int ARB_MAX_REQ = 8;
    localparam int ARB_CNT_W   = 16;

endpackage

// File: rtl/data_unpack_arb_rr_pick.sv
// Combinational round-robin picker: first requester after last_i, skipping
// any index set in excl_i.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] last_i,
    input  logic [N-1:0]  excl_i,
    output logic          found_o,
    output logic [IW-1:0] idx_o
);

    always_comb begin
        logic [IW-1:0] j;
        j       = '0;
        found_o = 1'b0;
        idx_o   = '0;
        for (int k = 1; k <= N; k++) begin
            j = IW'((int'(last_i) + k) % N);
            if (!found_o && req_i[j] && !excl_i[j]) begin
                found_o = 1'b1;
                idx_o   = j;
            end
        end
    end

endmodule

// File: rtl/data_unpack_arb.sv
// Packet-level round-robin arbiter feeding one data_unpack; grant held SOP..EOP.
// Define DATA_UNPACK_ARB_STATS_EN to add per-port packet/drop counters.
//
//   state  | meaning
//   IDLE   | no grant; sop words wait, stray words are dropped
//   LOCKED | grant_id forwarded to the unpacker until its EOP is accepted
module data_unpack_arb
    import data_unpack_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    parameter  int DATA_W  = 32,
    localparam int IW      = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_sop,
    input  logic [NUM_REQ-1:0]        req_eop,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [DATA_W-1:0]         m_data,
    output logic                      m_sop,
    output logic                      m_eop,
    output logic [IW-1:0]             grant_id,
    output logic                      busy,
`ifdef DATA_UNPACK_ARB_STATS_EN
    output logic                      proto_err,
    output logic [NUM_REQ*ARB_CNT_W-1:0] pkt_cnt_o,
    output logic [NUM_REQ*ARB_CNT_W-1:0] drop_cnt_o
`else
    output logic                      proto_err
`endif
);

    arb_state_t         state_q, state_d;
    logic [IW-1:0]      grant_q, grant_d, last_q, last_d;
    logic               first_q, first_d, perr_q, perr_d;
    logic               locked, g_valid, g_sop, g_eop, g_acc, g_eop_acc;
    logic [NUM_REQ-1:0] cand, excl;
    logic               pick_found;
    logic [IW-1:0]      pick_idx;

    assign locked    = (state_q == LOCKED);
    assign g_valid   = req_valid[grant_q];
    assign g_sop     = req_sop[grant_q];
    assign g_eop     = req_eop[grant_q];
    assign g_acc     = locked & g_valid & m_ready & ~rst;
    assign g_eop_acc = g_acc & g_eop;
    assign cand      = req_valid & req_sop;
    // While locked the current owner is excluded so hand-off prefers others.
    assign excl      = locked ? (NUM_REQ'(1) << grant_q) : '0;

    rr_pick #(.N(NUM_REQ)) u_pick (
        .req_i   (cand),
        .last_i  (last_q),
        .excl_i  (excl),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    assign m_valid   = locked & g_valid & ~rst;
    assign m_data    = locked ? req_data[grant_q*DATA_W +: DATA_W] : '0;
    assign m_sop     = locked & g_sop;
    assign m_eop     = locked & g_eop;
    assign grant_id  = grant_q;
    assign busy      = locked;
    assign proto_err = perr_q;

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (locked && grant_q == IW'(i))
                req_ready[i] = m_ready & ~rst;
            else
                req_ready[i] = req_valid[i] & ~req_sop[i] & ~rst;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        first_d = first_q;
        perr_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d = LOCKED;
                    grant_d = pick_idx;
                    last_d  = pick_idx;
                    first_d = 1'b1;
                end
            end
            LOCKED: begin
                if (g_acc) begin
                    first_d = 1'b0;
                    perr_d  = g_sop & ~first_q;
                    if (g_eop) begin
                        if (pick_found) begin
                            grant_d = pick_idx;
                            last_d  = pick_idx;
                            first_d = 1'b1;
                        end else if (g_valid && g_sop) begin
                            first_d = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= IW'(NUM_REQ - 1);
            first_q <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            first_q <= first_d;
            perr_q  <= perr_d;
        end
    end

`ifdef DATA_UNPACK_ARB_STATS_EN
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_stats
        logic [ARB_CNT_W-1:0] pkt_q, drop_q;
        logic                 is_grant, drop_ev, pkt_ev;

        assign is_grant = locked && (grant_q == IW'(i));
        assign drop_ev  = req_valid[i] & req_ready[i] & ~req_sop[i] & ~is_grant;
        assign pkt_ev   = g_eop_acc & is_grant;

        always_ff @(posedge clk) begin
            if (rst) begin
                pkt_q  <= '0;
                drop_q <= '0;
            end else begin
                if (pkt_ev && pkt_q != '1)
                    pkt_q <= pkt_q + 1'b1;
                if (drop_ev && drop_q != '1)
                    drop_q <= drop_q + 1'b1;
            end
        end

        assign pkt_cnt_o[i*ARB_CNT_W +: ARB_CNT_W]  = pkt_q;
        assign drop_cnt_o[i*ARB_CNT_W +: ARB_CNT_W] = drop_q;
    end
`endif

endmodule

// File: tb/tb_data_unpack_arb.sv
// Scoreboard bench for data_unpack_arb: per-port word queues drive the
// requesters, expected unpacker-side words are queued and checked by a monitor.
module tb_data_unpack_arb;

    localparam int NR = 4;
    localparam int DW = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NR-1:0]     req_valid, req_ready, req_sop, req_eop;
    logic [NR*DW-1:0]  req_data;
    logic              m_valid, m_ready, m_sop, m_eop, busy, proto_err;
    logic [DW-1:0]     m_data;
    logic [1:0]        grant_id;
`ifdef DATA_UNPACK_ARB_STATS_EN
    logic [NR*16-1:0]  pkt_cnt_o, drop_cnt_o;
`endif

    data_unpack_arb #(.NUM_REQ(NR), .DATA_W(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .req_sop   (req_sop),
        .req_eop   (req_eop),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_sop     (m_sop),
        .m_eop     (m_eop),
        .grant_id  (grant_id),
        .busy      (busy),
`ifdef DATA_UNPACK_ARB_STATS_EN
        .proto_err (proto_err),
        .pkt_cnt_o (pkt_cnt_o),
        .drop_cnt_o(drop_cnt_o)
`else
        .proto_err (proto_err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] data;
        logic        sop;
        logic        eop;
    } word_t;

    typedef struct packed {
        logic [31:0] data;
        logic        sop;
        logic        eop;
        logic        perr;
    } exp_t;

    word_t pq[NR][$];
    exp_t  exp_q[$];
    int    n_vec = 0;
    int    n_err = 0;
    int    pops  = 0;
    bit    toggle_mode = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    // sop_at: index of an extra (illegal) sop inside the packet, -1 for none
    task automatic push_pkt(input int port, input logic [31:0] base, input int len, input int sop_at);
        word_t w;
        exp_t  e;
        for (int k = 0; k < len; k++) begin
            w.data = base + 32'(k);
            w.sop  = (k == 0) || (k == sop_at);
            w.eop  = (k == len - 1);
            pq[port].push_back(w);
            e.data = w.data;
            e.sop  = w.sop;
            e.eop  = w.eop;
            e.perr = (k != 0) && (k == sop_at);
            exp_q.push_back(e);
        end
    endtask

    task automatic push_stray(input int port, input logic [31:0] base, input int n);
        word_t w;
        for (int k = 0; k < n; k++) begin
            w.data = base + 32'(k);
            w.sop  = 1'b0;
            w.eop  = 1'b0;
            pq[port].push_back(w);
        end
    endtask

    task automatic flush_all();
        for (int i = 0; i < NR; i++) pq[i].delete();
        exp_q.delete();
    endtask

    task automatic wait_drain(input string nm);
        bit done;
        done = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk); #1;
            if (exp_q.size() == 0 && pq[0].size() == 0 && pq[1].size() == 0 &&
                pq[2].size() == 0 && pq[3].size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        chk({nm, "_drained"}, 32'(done), 32'd1);
        if (!done) flush_all();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        flush_all();
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
    endtask

    // Requester driver: handshakes sampled mid-cycle, new words presented after the edge.
    initial begin : driver
        logic [NR-1:0] acc;
        req_valid = '0;
        req_data  = '0;
        req_sop   = '0;
        req_eop   = '0;
        m_ready   = 1'b1;
        forever begin
            @(negedge clk);
            acc = req_valid & req_ready;
            @(posedge clk); #1;
            for (int i = 0; i < NR; i++) begin
                if (acc[i] && pq[i].size() > 0) void'(pq[i].pop_front());
                if (pq[i].size() > 0) begin
                    req_valid[i]            = 1'b1;
                    req_data[i*DW +: DW]    = pq[i][0].data;
                    req_sop[i]              = pq[i][0].sop;
                    req_eop[i]              = pq[i][0].eop;
                end else begin
                    req_valid[i]            = 1'b0;
                    req_data[i*DW +: DW]    = '0;
                    req_sop[i]              = 1'b0;
                    req_eop[i]              = 1'b0;
                end
            end
            m_ready = toggle_mode ? ~m_ready : 1'b1;
        end
    end

    initial begin : monitor
        exp_t e;
        logic perr_exp, perr_nxt;
        perr_exp = 1'b0;
        forever begin
            @(negedge clk);
            perr_nxt = 1'b0;
            if (!rst) begin
                chk("proto_err", 32'(proto_err), 32'(perr_exp));
                if (busy) chk("ready_mirror", 32'(req_ready[grant_id]), 32'(m_ready));
                if (m_valid && m_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_word", m_data, 32'hDEAD_BEEF);
                    end else begin
                        e = exp_q.pop_front();
                        chk("m_data", m_data, e.data);
                        chk("m_sop", 32'(m_sop), 32'(e.sop));
                        chk("m_eop", 32'(m_eop), 32'(e.eop));
                        perr_nxt = e.perr;
                        pops++;
                    end
                end
            end
            perr_exp = perr_nxt;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk_reset_vals(input string nm);
        chk({nm, "_busy"},      32'(busy),      32'd0);
        chk({nm, "_m_valid"},   32'(m_valid),   32'd0);
        chk({nm, "_m_sop"},     32'(m_sop),     32'd0);
        chk({nm, "_m_eop"},     32'(m_eop),     32'd0);
        chk({nm, "_m_data"},    m_data,         32'd0);
        chk({nm, "_grant_id"},  32'(grant_id),  32'd0);
        chk({nm, "_req_ready"}, 32'(req_ready), 32'd0);
        chk({nm, "_proto_err"}, 32'(proto_err), 32'd0);
    endtask

    initial begin : stim
        bit found;
        int p0;

        repeat (2) @(negedge clk);
        chk_reset_vals("rst0");
        #1 rst = 1'b0;

        // single port 0, 7-word packet
        push_pkt(0, 32'h1000_0000, 7, -1);
        @(negedge clk);
        chk("t1_idle_busy", 32'(busy), 32'd0);
        chk("t1_idle_ready0", 32'(req_ready[0]), 32'd0);
        chk("t1_idle_mvalid", 32'(m_valid), 32'd0);
        @(negedge clk);
        chk("t1_busy", 32'(busy), 32'd1);
        chk("t1_grant", 32'(grant_id), 32'd0);
        chk("t1_first_sop", 32'(m_valid & m_sop), 32'd1);
        #1;
        wait_drain("t1");
        chk("t1_back_idle", 32'(busy), 32'd0);

        // ports 0/1/2 simultaneous: grants 0,1,2 with no bubble
        do_reset();
        push_pkt(0, 32'h2000_0000, 3, -1);
        push_pkt(1, 32'h2100_0000, 3, -1);
        push_pkt(2, 32'h2200_0000, 3, -1);
        found = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (m_valid) begin
                found = 1'b1;
                break;
            end
        end
        chk("t2_start", 32'(found), 32'd1);
        for (int k = 0; k < 9; k++) begin
            chk("t2_no_bubble", 32'(m_valid), 32'd1);
            chk("t2_grant", 32'(grant_id), 32'(k / 3));
            if (k < 8) @(negedge clk);
        end
        #1;
        wait_drain("t2");

        // stray words on port 3 while port 0 locked
        push_pkt(0, 32'h3000_0000, 6, -1);
        push_stray(3, 32'h3300_0000, 3);
        @(negedge clk);
        chk("t3_stray_ready", 32'(req_ready[3]), 32'd1);
        #1;
        wait_drain("t3");
`ifdef DATA_UNPACK_ARB_STATS_EN
        chk("t3_drop_cnt3", 32'(drop_cnt_o[3*16 +: 16]), 32'd3);
        chk("t3_pkt_cnt0",  32'(pkt_cnt_o[0 +: 16]),     32'd2);
        chk("t3_pkt_cnt1",  32'(pkt_cnt_o[16 +: 16]),    32'd1);
`endif

        // back-pressure toggling 1010 on a 5-word packet
        toggle_mode = 1'b1;
        push_pkt(2, 32'h4200_0000, 5, -1);
        wait_drain("t4");
        toggle_mode = 1'b0;
        repeat (2) @(negedge clk);
        #1;

        // protocol violation: sop on word 3 of port 1
        push_pkt(1, 32'h5100_0000, 5, 2);
        wait_drain("t5");

        // reset mid-packet on port 1, then port 0 must win against port 2
        p0 = pops;
        push_pkt(1, 32'h6100_0000, 5, -1);
        found = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk); #1;
            if (pops >= p0 + 2) begin
                found = 1'b1;
                break;
            end
        end
        chk("t6_mid_packet", 32'(found), 32'd1);
        rst = 1'b1;
        flush_all();
        @(negedge clk);
        chk_reset_vals("t6_rst");
`ifdef DATA_UNPACK_ARB_STATS_EN
        chk("t6_pkt_cnt1_clr", 32'(pkt_cnt_o[16 +: 16]), 32'd0);
`endif
        #1 rst = 1'b0;
        push_pkt(0, 32'h7000_0000, 2, -1);
        push_pkt(2, 32'h7200_0000, 2, -1);
        wait_drain("t6");

        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
